cpu7_csr_excp: RTL and testbench

Parametrised successor to the single-cause CSR file: it holds the privilege/exception CSRs (CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, TCFG, TVAL, TICLR). It arbitrates `N_EXC` synchronous exception sources by fixed priority, records cause and bad address, and handles ERTN return. It also runs a one-shot/periodic countdown timer and produces a level interrupt request. It sits beside the EXU and is read and written by the CSR instructions in E stage.

---
 rtl/cpu7_csr_excp_pkg.sv | 62 ++++++
 rtl/cpu7_csr_excp_pri.sv | 42 ++++
 rtl/cpu7_csr_excp.sv | 267 ++++++++++++++++++++++++++
 tb/tb_cpu7_csr_excp.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu7_csr_excp_pkg.sv
// cpu7_csr_excp_pkg
// Shared definitions for the CSR / exception block.
// Contents:
//   - CSR addresses (CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, TCFG, TVAL, TICLR)
//   - field bit positions of those registers
//   - exception Ecode constants
//   - mode_t: the {IE, PLV} pair shared by CRMD and PRMD
package cpu7_csr_excp_pkg;

    // CSR addresses
    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    // Field positions
    localparam int MODE_PLV_LO    = 0;
    localparam int MODE_PLV_HI    = 1;
    localparam int MODE_IE        = 2;
    localparam int ECFG_LIE_HI    = 12;
    localparam int ESTAT_IS_HI    = 12;
    localparam int ESTAT_SW_HI    = 1;
    localparam int ESTAT_HW_LO    = 2;
    localparam int ESTAT_HW_HI    = 9;
    localparam int ESTAT_TI       = 11;
    localparam int ESTAT_ECODE_LO = 16;
    localparam int ESTAT_ECODE_HI = 21;
    localparam int TCFG_EN        = 0;
    localparam int TCFG_PERIODIC  = 1;
    localparam int TCFG_INIT_LO   = 2;
    localparam int TICLR_CLR      = 0;

    localparam int ECODE_W = 6;

    // Ecode values
    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_PIL = 6'h01;
    localparam logic [5:0] ECODE_PIS = 6'h02;
    localparam logic [5:0] ECODE_PIF = 6'h03;
    localparam logic [5:0] ECODE_PME = 6'h04;
    localparam logic [5:0] ECODE_PPI = 6'h07;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;
    localparam logic [5:0] ECODE_IPE = 6'h0E;
    localparam logic [5:0] ECODE_FPD = 6'h0F;

    // Privilege/interrupt-enable pair, laid out as in CRMD[2:0] / PRMD[2:0]
    typedef struct packed {
        logic       ie;
        logic [1:0] plv;
    } mode_t;

endpackage

// File: rtl/cpu7_csr_excp_pri.sv
// cpu7_csr_excp_pri
// Fixed-priority one-hot arbiter over N_EXC exception requests; index 0 has
// the highest priority. Also returns the Ecode of the winning source.
// Ports:
//   req      in  N_EXC          request vector
//   code_in  in  N_EXC*ECODE_W  per-source Ecode, source i at [i*ECODE_W +: ECODE_W]
//   grant    out N_EXC          one-hot winner (all zero when req is zero)
//   code_out out ECODE_W        Ecode of the winner (zero when no request)
module cpu7_csr_excp_pri #(
    parameter int N_EXC   = 4,
    parameter int ECODE_W = 6
) (
    input  logic [N_EXC-1:0]         req,
    input  logic [N_EXC*ECODE_W-1:0] code_in,
    output logic [N_EXC-1:0]         grant,
    output logic [ECODE_W-1:0]       code_out
);

    logic [ECODE_W-1:0] masked_code [N_EXC];

    genvar gi;
    generate
        for (gi = 0; gi < N_EXC; gi++) begin : g_grant
            if (gi == 0) begin : g_first
                assign grant[gi] = req[gi];
            end else begin : g_rest
                // A source wins only if no lower-indexed source is requesting.
                assign grant[gi] = req[gi] & ~(|req[gi-1:0]);
            end
            assign masked_code[gi] = code_in[gi*ECODE_W +: ECODE_W] & {ECODE_W{grant[gi]}};
        end
    endgenerate

    // grant is one-hot, so OR-reducing the masked codes selects the winner's.
    always_comb begin
        code_out = '0;
        for (int i = 0; i < N_EXC; i++) begin
            code_out = code_out | masked_code[i];
        end
    end

endmodule

// File: rtl/cpu7_csr_excp.sv
// cpu7_csr_excp
// Privilege/exception CSR file: CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY and,
// when built with CPU7_CSR_TIMER_EN, the countdown timer (TCFG, TVAL, TICLR, TI).
// Arbitrates N_EXC synchronous exception sources, records cause/bad address,
// handles ERTN, and produces a registered level interrupt request.
// Build option:
//   CPU7_CSR_TIMER_EN  defined: timer implemented; undefined: timer addresses
//                      read 0, ignore writes, IS[11] tied 0, no timer flops.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   csr_raddr/csr_rdata    combinational CSR read (unimplemented -> 0)
//   csr_waddr/wdata/wen    CSR write, applied at the clock edge
//   excp_vec_e/ecode_e     per-source exception requests and Ecodes
//   excp_badv_e            faulting address
//   ifu_exu_pc_e           PC of the E-stage instruction
//   ertn_e                 ERTN retiring in E
//   hw_int                 external interrupt levels
//   csr_eentry, csr_era    current EENTRY / ERA
//   csr_excp_sel           one-hot winning source (combinational)
//   csr_int                registered interrupt request
module cpu7_csr_excp
    import cpu7_csr_excp_pkg::*;
#(
    parameter int                 GRLEN     = 32,
    parameter int                 N_EXC     = 4,
    parameter logic [N_EXC-1:0]   BADV_MASK = N_EXC'(1),
    parameter int                 TIMER_W   = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [13:0]              csr_raddr,
    output logic [GRLEN-1:0]         csr_rdata,
    input  logic [13:0]              csr_waddr,
    input  logic [GRLEN-1:0]         csr_wdata,
    input  logic                     csr_wen,
    input  logic [N_EXC-1:0]         excp_vec_e,
    input  logic [N_EXC*ECODE_W-1:0] excp_ecode_e,
    input  logic [GRLEN-1:0]         excp_badv_e,
    input  logic [GRLEN-1:0]         ifu_exu_pc_e,
    input  logic                     ertn_e,
    input  logic [7:0]               hw_int,
    output logic [GRLEN-1:0]         csr_eentry,
    output logic [GRLEN-1:0]         csr_era,
    output logic [N_EXC-1:0]         csr_excp_sel,
    output logic                     csr_int
);

    // ------------------------------------------------------------------
    // Exception arbitration
    // ------------------------------------------------------------------
    logic [ECODE_W-1:0] win_ecode;
    logic               excp_taken;
    logic               badv_hit;

    cpu7_csr_excp_pri #(
        .N_EXC   (N_EXC),
        .ECODE_W (ECODE_W)
    ) u_pri (
        .req      (excp_vec_e),
        .code_in  (excp_ecode_e),
        .grant    (csr_excp_sel),
        .code_out (win_ecode)
    );

    assign excp_taken = |excp_vec_e;
    assign badv_hit   = |(csr_excp_sel & BADV_MASK);

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv, wr_eentry;

    assign wr_crmd   = csr_wen && (csr_waddr == CSR_CRMD);
    assign wr_prmd   = csr_wen && (csr_waddr == CSR_PRMD);
    assign wr_ecfg   = csr_wen && (csr_waddr == CSR_ECFG);
    assign wr_estat  = csr_wen && (csr_waddr == CSR_ESTAT);
    assign wr_era    = csr_wen && (csr_waddr == CSR_ERA);
    assign wr_badv   = csr_wen && (csr_waddr == CSR_BADV);
    assign wr_eentry = csr_wen && (csr_waddr == CSR_EENTRY);

    // Not every write-data bit lands in a register for every configuration.
    logic unused_wdata;
    assign unused_wdata = ^csr_wdata;

    // ------------------------------------------------------------------
    // Core CSR state
    // ------------------------------------------------------------------
    mode_t                     crmd_reg;
    mode_t                     prmd_reg;
    logic [ECFG_LIE_HI:0]      ecfg_lie_reg;
    logic [ESTAT_SW_HI:0]      is_sw_reg;
    logic [7:0]                is_hw_reg;
    logic [ECODE_W-1:0]        ecode_reg;
    logic [GRLEN-1:0]          era_reg;
    logic [GRLEN-1:0]          badv_reg;
    logic [GRLEN-1:0]          eentry_reg;
    logic                      csr_int_reg;
    logic                      ti_flag;

    // Exception > ERTN > CSR write for CRMD.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd_reg <= '0;
        end else if (excp_taken) begin
            crmd_reg <= '0;
        end else if (ertn_e) begin
            crmd_reg <= prmd_reg;
        end else if (wr_crmd) begin
            crmd_reg.plv <= csr_wdata[MODE_PLV_HI:MODE_PLV_LO];
            crmd_reg.ie  <= csr_wdata[MODE_IE];
        end
    end

    // Fields that an exception rewrites; a same-cycle CSR write to them is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prmd_reg  <= '0;
            era_reg   <= '0;
            badv_reg  <= '0;
            ecode_reg <= '0;
        end else if (excp_taken) begin
            prmd_reg  <= crmd_reg;
            era_reg   <= ifu_exu_pc_e;
            ecode_reg <= win_ecode;
            if (badv_hit) begin
                badv_reg <= excp_badv_e;
            end
        end else begin
            if (wr_prmd) begin
                prmd_reg.plv <= csr_wdata[MODE_PLV_HI:MODE_PLV_LO];
                prmd_reg.ie  <= csr_wdata[MODE_IE];
            end
            if (wr_era) begin
                era_reg <= csr_wdata;
            end
            if (wr_badv) begin
                badv_reg <= csr_wdata;
            end
        end
    end

    // Registers and fields untouched by exceptions.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ecfg_lie_reg <= '0;
            is_sw_reg    <= '0;
            is_hw_reg    <= '0;
            eentry_reg   <= '0;
        end else begin
            is_hw_reg <= hw_int;
            if (wr_ecfg) begin
                ecfg_lie_reg <= csr_wdata[ECFG_LIE_HI:0];
            end
            if (wr_estat) begin
                is_sw_reg <= csr_wdata[ESTAT_SW_HI:0];
            end
            if (wr_eentry) begin
                eentry_reg <= csr_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
`ifdef CPU7_CSR_TIMER_EN
    logic [TIMER_W-1:0] tcfg_reg;
    logic [TIMER_W-1:0] tval_reg;
    logic               ti_reg;
    logic               wr_tcfg;
    logic               wr_ticlr;
    logic               timer_expire;
    logic [TIMER_W-1:0] tcfg_reload;

    assign wr_tcfg      = csr_wen && (csr_waddr == CSR_TCFG);
    assign wr_ticlr     = csr_wen && (csr_waddr == CSR_TICLR);
    assign tcfg_reload  = {tcfg_reg[TIMER_W-1:TCFG_INIT_LO], 2'b00};
    // A TCFG write in the same cycle suppresses expiry entirely.
    assign timer_expire = !wr_tcfg && tcfg_reg[TCFG_EN] && (tval_reg == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcfg_reg <= '0;
            tval_reg <= '0;
        end else if (wr_tcfg) begin
            tcfg_reg <= csr_wdata[TIMER_W-1:0];
            tval_reg <= {csr_wdata[TIMER_W-1:TCFG_INIT_LO], 2'b00};
        end else if (tcfg_reg[TCFG_EN]) begin
            if (tval_reg != '0) begin
                tval_reg <= tval_reg - TIMER_W'(1);
            end else if (tcfg_reg[TCFG_PERIODIC]) begin
                tval_reg <= tcfg_reload;
            end else begin
                tcfg_reg[TCFG_EN] <= 1'b0;
            end
        end
    end

    // Setting TI takes precedence over a same-cycle TICLR clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ti_reg <= 1'b0;
        end else if (timer_expire) begin
            ti_reg <= 1'b1;
        end else if (wr_ticlr && csr_wdata[TICLR_CLR]) begin
            ti_reg <= 1'b0;
        end
    end

    assign ti_flag = ti_reg;
`else
    assign ti_flag = 1'b0;
`endif

    // ------------------------------------------------------------------
    // ESTAT view and interrupt request
    // ------------------------------------------------------------------
    logic [ESTAT_IS_HI:0] estat_is;
    logic [GRLEN-1:0]     estat_val;

    always_comb begin
        estat_is                           = '0;
        estat_is[ESTAT_SW_HI:0]            = is_sw_reg;
        estat_is[ESTAT_HW_HI:ESTAT_HW_LO]  = is_hw_reg;
        estat_is[ESTAT_TI]                 = ti_flag;
    end

    always_comb begin
        estat_val                                = '0;
        estat_val[ESTAT_IS_HI:0]                 = estat_is;
        estat_val[ESTAT_ECODE_HI:ESTAT_ECODE_LO] = ecode_reg;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csr_int_reg <= 1'b0;
        end else begin
            csr_int_reg <= crmd_reg.ie & (|(estat_is & ecfg_lie_reg));
        end
    end

    // ------------------------------------------------------------------
    // Read mux and outputs
    // ------------------------------------------------------------------
    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            CSR_CRMD:   csr_rdata = GRLEN'(crmd_reg);
            CSR_PRMD:   csr_rdata = GRLEN'(prmd_reg);
            CSR_ECFG:   csr_rdata = GRLEN'(ecfg_lie_reg);
            CSR_ESTAT:  csr_rdata = estat_val;
            CSR_ERA:    csr_rdata = era_reg;
            CSR_BADV:   csr_rdata = badv_reg;
            CSR_EENTRY: csr_rdata = eentry_reg;
`ifdef CPU7_CSR_TIMER_EN
            CSR_TCFG:   csr_rdata = GRLEN'(tcfg_reg);
            CSR_TVAL:   csr_rdata = GRLEN'(tval_reg);
`endif
            default:    csr_rdata = '0;
        endcase
    end

    assign csr_eentry = eentry_reg;
    assign csr_era    = era_reg;
    assign csr_int    = csr_int_reg;

endmodule

// File: tb/tb_cpu7_csr_excp.sv
module tb_cpu7_csr_excp;

    localparam logic [13:0] A_CRMD   = 14'h000;
    localparam logic [13:0] A_PRMD   = 14'h001;
    localparam logic [13:0] A_ECFG   = 14'h004;
    localparam logic [13:0] A_ESTAT  = 14'h005;
    localparam logic [13:0] A_ERA    = 14'h006;
    localparam logic [13:0] A_BADV   = 14'h007;
    localparam logic [13:0] A_EENTRY = 14'h00C;
    localparam logic [13:0] A_TCFG   = 14'h041;
    localparam logic [13:0] A_TVAL   = 14'h042;
    localparam logic [13:0] A_TICLR  = 14'h044;

    logic        clk;
    logic        resetn;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_wen;
    logic [3:0]  excp_vec_e;
    logic [23:0] excp_ecode_e;
    logic [31:0] excp_badv_e;
    logic [31:0] ifu_exu_pc_e;
    logic        ertn_e;
    logic [7:0]  hw_int;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic [3:0]  csr_excp_sel;
    logic        csr_int;

    int n_checks = 0;
    int n_fail   = 0;

    cpu7_csr_excp #(
        .GRLEN     (32),
        .N_EXC     (4),
        .BADV_MASK (4'b0001),
        .TIMER_W   (32)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .csr_raddr    (csr_raddr),
        .csr_rdata    (csr_rdata),
        .csr_waddr    (csr_waddr),
        .csr_wdata    (csr_wdata),
        .csr_wen      (csr_wen),
        .excp_vec_e   (excp_vec_e),
        .excp_ecode_e (excp_ecode_e),
        .excp_badv_e  (excp_badv_e),
        .ifu_exu_pc_e (ifu_exu_pc_e),
        .ertn_e       (ertn_e),
        .hw_int       (hw_int),
        .csr_eentry   (csr_eentry),
        .csr_era      (csr_era),
        .csr_excp_sel (csr_excp_sel),
        .csr_int      (csr_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Combinational CSR read, sampled 1 ns after setting the address.
    task automatic chk_csr(input string tag, input logic [13:0] addr, input logic [31:0] exp);
        csr_raddr = addr;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [13:0] addr, input logic [31:0] data);
        csr_wen   = 1'b1;
        csr_waddr = addr;
        csr_wdata = data;
        tick();
        csr_wen   = 1'b0;
    endtask

    initial begin
        resetn       = 1'b0;
        csr_raddr    = '0;
        csr_waddr    = '0;
        csr_wdata    = '0;
        csr_wen      = 1'b0;
        excp_vec_e   = '0;
        // code3=0x0B, code2=0x0D, code1=0x09, code0=0x08
        excp_ecode_e = {6'h0B, 6'h0D, 6'h09, 6'h08};
        excp_badv_e  = '0;
        ifu_exu_pc_e = '0;
        ertn_e       = 1'b0;
        hw_int       = '0;

        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Reset state
        chk_csr("rst_crmd", A_CRMD, 32'h0);
        chk_csr("rst_estat", A_ESTAT, 32'h0);
        chk_csr("rst_era", A_ERA, 32'h0);
        check("rst_eentry", csr_eentry, 32'h0);
        check("rst_int", {31'b0, csr_int}, 32'h0);
        check("rst_sel", {28'b0, csr_excp_sel}, 32'h0);

        // Plain writes
        csr_write(A_EENTRY, 32'h1C00_8000);
        check("eentry_out", csr_eentry, 32'h1C00_8000);
        csr_write(A_BADV, 32'hDEAD_BEEF);
        chk_csr("badv_wr", A_BADV, 32'hDEAD_BEEF);
        csr_write(A_CRMD, 32'h7);
        chk_csr("crmd_wr", A_CRMD, 32'h7);

        // Exception from sources 1 and 2: source 1 wins, BADV not updated
        excp_vec_e   = 4'b0110;
        ifu_exu_pc_e = 32'h1C00_0040;
        excp_badv_e  = 32'h1234_5678;
        #1;
        check("sel_0110", {28'b0, csr_excp_sel}, 32'h2);
        tick();
        excp_vec_e = '0;
        chk_csr("ex1_crmd", A_CRMD, 32'h0);
        chk_csr("ex1_prmd", A_PRMD, 32'h7);
        chk_csr("ex1_era", A_ERA, 32'h1C00_0040);
        chk_csr("ex1_estat", A_ESTAT, 32'h0009_0000);
        chk_csr("ex1_badv", A_BADV, 32'hDEAD_BEEF);
        check("ex1_era_out", csr_era, 32'h1C00_0040);

        // Exception (sources 0 and 3) with ERTN and CRMD write in the same cycle
        excp_vec_e   = 4'b1001;
        ertn_e       = 1'b1;
        ifu_exu_pc_e = 32'h1C00_0080;
        excp_badv_e  = 32'hA5A5_0004;
        csr_wen      = 1'b1;
        csr_waddr    = A_CRMD;
        csr_wdata    = 32'h3;
        #1;
        check("sel_1001", {28'b0, csr_excp_sel}, 32'h1);
        tick();
        excp_vec_e = '0;
        ertn_e     = 1'b0;
        csr_wen    = 1'b0;
        chk_csr("ex2_crmd", A_CRMD, 32'h0);
        chk_csr("ex2_prmd", A_PRMD, 32'h0);
        chk_csr("ex2_era", A_ERA, 32'h1C00_0080);
        chk_csr("ex2_estat", A_ESTAT, 32'h0008_0000);
        chk_csr("ex2_badv", A_BADV, 32'hA5A5_0004);

        // Exception with ESTAT write: IS[1:0] lands, Ecode from exception
        excp_vec_e   = 4'b0100;
        ifu_exu_pc_e = 32'h1C00_00C0;
        excp_badv_e  = 32'h0BAD_0BAD;
        csr_wen      = 1'b1;
        csr_waddr    = A_ESTAT;
        csr_wdata    = 32'h003F_0003;
        tick();
        excp_vec_e = '0;
        csr_wen    = 1'b0;
        chk_csr("ex3_estat", A_ESTAT, 32'h000D_0003);
        chk_csr("ex3_badv", A_BADV, 32'hA5A5_0004);
        csr_write(A_ESTAT, 32'h0);
        chk_csr("estat_clr", A_ESTAT, 32'h000D_0000);

        // ERTN
        csr_write(A_PRMD, 32'h5);
        chk_csr("prmd_wr", A_PRMD, 32'h5);
        ertn_e = 1'b1;
        tick();
        ertn_e = 1'b0;
        chk_csr("ertn_crmd", A_CRMD, 32'h5);
        chk_csr("ertn_prmd", A_PRMD, 32'h5);
        chk_csr("unimpl_rd", 14'h0123, 32'h0);

        // Software interrupt IS[1] with LIE[1], CRMD.IE=1
        csr_write(A_ECFG, 32'h2);
        csr_write(A_ESTAT, 32'h2);
        check("swi_lag", {31'b0, csr_int}, 32'h0);
        tick();
        check("swi_on", {31'b0, csr_int}, 32'h1);
        csr_write(A_ESTAT, 32'h0);
        check("swi_hold", {31'b0, csr_int}, 32'h1);
        tick();
        check("swi_off", {31'b0, csr_int}, 32'h0);

        // Hardware interrupt hw_int[2] -> IS[4], LIE[4]
        csr_write(A_ECFG, 32'h10);
        hw_int = 8'h04;
        tick();
        chk_csr("hwi_estat", A_ESTAT, 32'h000D_0010);
        check("hwi_lag", {31'b0, csr_int}, 32'h0);
        tick();
        check("hwi_on", {31'b0, csr_int}, 32'h1);
        hw_int = 8'h00;
        tick();
        tick();
        check("hwi_off", {31'b0, csr_int}, 32'h0);

`ifdef CPU7_CSR_TIMER_EN
        // Periodic timer, InitVal 2 -> TVAL 8
        csr_write(A_ECFG, 32'h800);
        csr_write(A_TCFG, 32'hB);
        chk_csr("tcfg_rd", A_TCFG, 32'hB);
        chk_csr("tval_load", A_TVAL, 32'h8);
        for (int v = 7; v >= 0; v--) begin
            tick();
            chk_csr($sformatf("tval_%0d", v), A_TVAL, 32'(v));
        end
        chk_csr("ti_pre", A_ESTAT, 32'h000D_0000);
        // TICLR on the expiry cycle: set wins
        csr_write(A_TICLR, 32'h1);
        chk_csr("tval_reload", A_TVAL, 32'h8);
        chk_csr("ti_set_wins", A_ESTAT, 32'h000D_0800);
        check("tint_lag", {31'b0, csr_int}, 32'h0);
        tick();
        check("tint_on", {31'b0, csr_int}, 32'h1);
        chk_csr("tval_7b", A_TVAL, 32'h7);
        tick();
        tick();
        chk_csr("tval_5", A_TVAL, 32'h5);

        // Asynchronous reset mid-countdown
        resetn = 1'b0;
        #1;
        chk_csr("arst_tval", A_TVAL, 32'h0);
        chk_csr("arst_tcfg", A_TCFG, 32'h0);
        check("arst_int", {31'b0, csr_int}, 32'h0);
        resetn = 1'b1;
        tick();
        tick();
        chk_csr("post_rst_tval", A_TVAL, 32'h0);
        chk_csr("post_rst_estat", A_ESTAT, 32'h0);

        // One-shot timer, InitVal 1 -> TVAL 4
        csr_write(A_CRMD, 32'h4);
        csr_write(A_ECFG, 32'h800);
        csr_write(A_TCFG, 32'h5);
        chk_csr("os_load", A_TVAL, 32'h4);
        tick(); tick(); tick(); tick();
        chk_csr("os_zero", A_TVAL, 32'h0);
        chk_csr("os_ti_pre", A_ESTAT, 32'h0);
        tick();
        chk_csr("os_ti", A_ESTAT, 32'h800);
        chk_csr("os_en_clr", A_TCFG, 32'h4);
        tick();
        chk_csr("os_tval_hold", A_TVAL, 32'h0);
        check("os_int_on", {31'b0, csr_int}, 32'h1);
        csr_write(A_TICLR, 32'h1);
        chk_csr("ticlr", A_ESTAT, 32'h0);
        chk_csr("ticlr_rd", A_TICLR, 32'h0);
        check("ticlr_int_hold", {31'b0, csr_int}, 32'h1);
        tick();
        check("ticlr_int_off", {31'b0, csr_int}, 32'h0);
`else
        // Timer absent: addresses read 0 and ignore writes
        csr_write(A_TCFG, 32'hB);
        chk_csr("not_tcfg", A_TCFG, 32'h0);
        tick();
        chk_csr("not_tval", A_TVAL, 32'h0);
        chk_csr("not_ti", A_ESTAT, 32'h000D_0000);

        // Asynchronous reset clears a pending csr_int
        csr_write(A_ECFG, 32'h2);
        csr_write(A_ESTAT, 32'h2);
        tick();
        check("pre_arst_int", {31'b0, csr_int}, 32'h1);
        resetn = 1'b0;
        #1;
        check("arst_int", {31'b0, csr_int}, 32'h0);
        chk_csr("arst_crmd", A_CRMD, 32'h0);
        resetn = 1'b1;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
